// File: rtl/rv_perf_counters.sv
// rv_perf_counters: mcycle/minstret plus programmable hpm counters.
// CSR read/write/set/clear port with a registered one-cycle response.
module rv_perf_counters #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  csr_req,
    input  logic [11:0]           csr_addr,
    input  logic [1:0]            csr_op,
    input  logic [31:0]           csr_wdata,
    output logic                  csr_ack,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal
);

    // Slot 0 = mcycle, slot 1 = minstret, slot 2+j = mhpmcounter(3+j).
    localparam int NCNT = NUM_HPM + 2;
    localparam int NSEL = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK =
        32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [7:0]           evsel [NSEL];
    logic [31:0]          inhibit;

    logic                 hi, ro_alias;
    logic                 is_cnt, is_inh, is_sel, legal, wr_en;
    int                   idx, slot, sel_slot;
    logic [63:0]          old_full;
    logic [CNT_WIDTH-1:0] old_cnt, new_cnt;
    logic [31:0]          old_val, new_val;
    logic [NCNT-1:0]      inc;

    // Address decode, old-value mux and read-modify-write operand.
    always_comb begin
        idx      = int'(csr_addr[4:0]);
        hi       = csr_addr[7];
        ro_alias = (csr_addr[11:8] == 4'hC);
        is_cnt   = (csr_addr[11:8] == 4'hB || ro_alias) &&
                   (csr_addr[6:5] == 2'b00) &&
                   (idx == 0 || idx == 2 ||
                    (idx >= 3 && idx < 3 + NUM_HPM));
        is_inh   = (csr_addr == 12'h320);
        is_sel   = (csr_addr[11:5] == 7'b0011001) &&
                   (idx >= 3) && (idx < 3 + NUM_HPM);
        legal    = (is_cnt && !(ro_alias && csr_op != 2'b00)) ||
                   is_inh || is_sel;
        slot     = (idx == 0) ? 0 : ((idx == 2) ? 1 : idx - 1);
        sel_slot = idx - 3;
        wr_en    = csr_req && legal && (csr_op != 2'b00);

        old_cnt  = '0;
        for (int s = 0; s < NCNT; s++) begin
            if (slot == s) old_cnt = cnt[s];
        end
        old_full = '0;
        old_full[CNT_WIDTH-1:0] = old_cnt;

        old_val = '0;
        if (is_cnt) begin
            old_val = hi ? old_full[63:32] : old_full[31:0];
        end else if (is_inh) begin
            old_val = inhibit;
        end else if (is_sel) begin
            for (int j = 0; j < NUM_HPM; j++) begin
                if (sel_slot == j) old_val = {24'b0, evsel[j]};
            end
        end

        unique case (csr_op)
            2'b00: new_val = old_val;
            2'b01: new_val = csr_wdata;
            2'b10: new_val = old_val | csr_wdata;
            2'b11: new_val = old_val & ~csr_wdata;
        endcase

        new_cnt = old_cnt;
        if (hi) new_cnt[CNT_WIDTH-1:32] = new_val[CNT_WIDTH-33:0];
        else    new_cnt[31:0] = new_val;
    end

    // Per-counter increment enables from inhibit mask and event selectors.
    always_comb begin
        inc    = '0;
        inc[0] = !inhibit[0];
        inc[1] = retire && !inhibit[2];
        for (int j = 0; j < NUM_HPM; j++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (int'(evsel[j]) == e + 1 && event_in[e]) begin
                    inc[2+j] = !inhibit[3+j];
                end
            end
        end
    end

    // Counter/CSR state update and registered response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < NCNT; s++) cnt[s] <= '0;
            for (int j = 0; j < NSEL; j++) evsel[j] <= '0;
            inhibit     <= '0;
            csr_ack     <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
        end else begin
            csr_ack <= csr_req;
            if (csr_req) begin
                csr_rdata   <= legal ? old_val : 32'h0;
                csr_illegal <= !legal;
            end
            for (int s = 0; s < NCNT; s++) begin
                if (wr_en && is_cnt && slot == s) begin
                    cnt[s] <= new_cnt;
                end else if (inc[s]) begin
                    cnt[s] <= cnt[s] + CNT_WIDTH'(1);
                end
            end
            if (wr_en && is_inh) inhibit <= new_val & INH_MASK;
            for (int j = 0; j < NUM_HPM; j++) begin
                if (wr_en && is_sel && sel_slot == j) begin
                    evsel[j] <= new_val[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_perf_counters.sv
// tb_rv_perf_counters: directed CSR accesses with a response scoreboard.
// Stimulus pushes expected responses; a monitor pops them on each ack.
module tb_rv_perf_counters;

    logic        clk = 1'b0;
    logic        resetn;
    logic        retire;
    logic [7:0]  event_in;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rd;
        logic        ill;
        logic        dc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    logic done = 1'b0;

    rv_perf_counters #(
        .NUM_HPM(4),
        .CNT_WIDTH(40),
        .NUM_EVENTS(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .retire(retire),
        .event_in(event_in),
        .csr_req(csr_req),
        .csr_addr(csr_addr),
        .csr_op(csr_op),
        .csr_wdata(csr_wdata),
        .csr_ack(csr_ack),
        .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic csr(input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic [31:0] ex,
                       input logic ill, input logic dc);
        exp_t n;
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = wd;
        n.addr = a;
        n.rd   = ex;
        n.ill  = ill;
        n.dc   = dc;
        q.push_back(n);
        @(negedge clk);
        csr_req = 1'b0;
        csr_op  = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: sample just after each rising edge, score every ack.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            checks++;
            if (csr_ack !== 1'b0 || csr_rdata !== 32'h0 ||
                csr_illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_state ack=%b rdata=%h ill=%b want 0/0/0",
                         csr_ack, csr_rdata, csr_illegal);
            end
        end else if (csr_ack) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_ack rdata=%h ill=%b want no ack",
                         csr_rdata, csr_illegal);
            end else begin
                e = q.pop_front();
                if (csr_illegal !== e.ill ||
                    (!e.dc && csr_rdata !== e.rd)) begin
                    errors++;
                    $display("FAIL csr_%h rdata=%h ill=%b want rdata=%h ill=%b",
                             e.addr, csr_rdata, csr_illegal, e.rd, e.ill);
                end
            end
        end
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL missing_ack outstanding=%0d want 0", q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout pending=%0d want 0", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        retire    = 1'b0;
        event_in  = 8'h00;
        csr_req   = 1'b1;
        csr_op    = 2'b01;
        csr_addr  = 12'hB02;
        csr_wdata = 32'h55;
        idle(4);
        csr_req = 1'b0;
        csr_op  = 2'b00;
        resetn  = 1'b1;

        idle(10);
        csr(2'b00, 12'hC00, 0, 32'd10, 0, 0);
        csr(2'b00, 12'hC80, 0, 32'd0, 0, 0);

        repeat (5) begin
            retire = 1'b1;
            idle(1);
            retire = 1'b0;
            idle(1);
        end
        csr(2'b00, 12'hB02, 0, 32'd5, 0, 0);
        csr(2'b10, 12'h320, 32'h4, 32'h0, 0, 0);
        repeat (3) begin
            retire = 1'b1;
            idle(1);
            retire = 1'b0;
            idle(1);
        end
        csr(2'b00, 12'hB02, 0, 32'd5, 0, 0);
        csr(2'b00, 12'h320, 0, 32'h4, 0, 0);
        csr(2'b01, 12'h320, 32'hFFFF_FFFF, 32'h4, 0, 0);
        csr(2'b01, 12'h320, 32'h0, 32'h7D, 0, 0);

        csr(2'b01, 12'hB80, 32'hFF, 32'h0, 0, 0);
        csr(2'b01, 12'hB00, 32'hFFFF_FFFE, 32'h0, 0, 1);
        idle(3);
        csr(2'b00, 12'hB00, 0, 32'd1, 0, 0);
        csr(2'b00, 12'hB80, 0, 32'd0, 0, 0);
        csr(2'b01, 12'hB80, 32'hFFFF_FF01, 32'h0, 0, 0);
        csr(2'b00, 12'hB80, 0, 32'h1, 0, 0);

        csr(2'b01, 12'h323, 32'd2, 32'h0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            event_in = 8'h02 | 8'(i & 1);
            idle(1);
        end
        event_in = 8'h00;
        csr(2'b00, 12'hB03, 0, 32'd7, 0, 0);
        csr(2'b00, 12'h323, 0, 32'd2, 0, 0);
        csr(2'b01, 12'h323, 32'd9, 32'd2, 0, 0);
        event_in = 8'hFF;
        idle(5);
        event_in = 8'h00;
        csr(2'b00, 12'hB03, 0, 32'd7, 0, 0);
        csr(2'b00, 12'hB04, 0, 32'd0, 0, 0);
        csr(2'b01, 12'h323, 32'd8, 32'd9, 0, 0);
        event_in = 8'h80;
        idle(4);
        event_in = 8'h00;
        csr(2'b00, 12'hB03, 0, 32'd11, 0, 0);

        csr(2'b01, 12'hC00, 32'd5, 32'h0, 1, 0);
        csr(2'b00, 12'h7FF, 0, 32'h0, 1, 0);
        csr(2'b00, 12'hB07, 0, 32'h0, 1, 0);
        csr(2'b01, 12'hB07, 32'd3, 32'h0, 1, 0);
        csr(2'b00, 12'hB01, 0, 32'h0, 1, 0);
        csr(2'b01, 12'h321, 32'd1, 32'h0, 1, 0);
        csr(2'b01, 12'hC02, 32'd99, 32'h0, 1, 0);
        csr(2'b00, 12'hB02, 0, 32'd5, 0, 0);
        csr(2'b00, 12'hB06, 0, 32'd0, 0, 0);
        csr(2'b00, 12'hC03, 0, 32'd11, 0, 0);

        csr(2'b01, 12'hB00, 32'd100, 32'h0, 0, 1);
        csr(2'b11, 12'hB00, 32'hFFFF_FFFF, 32'd100, 0, 0);
        csr(2'b00, 12'hB00, 0, 32'd0, 0, 0);
        csr(2'b00, 12'hB00, 0, 32'd1, 0, 0);
        csr(2'b00, 12'hB80, 0, 32'd1, 0, 0);

        idle(2);
        done = 1'b1;
        idle(5);
    end

endmodule

// File: doc/rv_perf_counters.md
Name: rv_perf_counters

Overview:
Parametrised RISC-V counter/CSR unit that replaces the fixed cycle/instret pair in the multi-cycle core. It provides mcycle, minstret and NUM_HPM programmable event counters (mhpmcounter3..), with event selectors (mhpmevent), an inhibit mask (mcountinhibit), and read/write/set/clear CSR access. The core's SYSTEM decode drives one request per CSR instruction and gets a registered response one cycle later.

Parameters:
NUM_HPM, 4, number of programmable counters (0..29), mapped at index 3..3+NUM_HPM-1
CNT_WIDTH, 64, implemented counter width (33..64); unimplemented bits read 0 and ignore writes
NUM_EVENTS, 8, width of event_in (1..255)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
retire  in  1  one-cycle pulse per retired instruction
event_in  in  NUM_EVENTS  per-cycle event strobes (level sampled each cycle)
csr_req  in  1  CSR access request (single cycle)
csr_addr  in  12  CSR address (instr[31:20])
csr_op  in  2  01=write, 10=set, 11=clear, 00=read only
csr_wdata  in  32  operand (rs1 value or zimm)
csr_ack  out  1  response valid, exactly one cycle after csr_req
csr_rdata  out  32  old CSR value (before this request's write)
csr_illegal  out  1  valid with csr_ack; access rejected

Behaviour:
- Reset (resetn=0 at clk edge): all counters, mhpmevent, mcountinhibit = 0; csr_ack=0, csr_rdata=0, csr_illegal=0. A request presented during reset is dropped (no ack).
- Address map: mcycle 0xB00/0xB80 (lo/hi), minstret 0xB02/0xB82, mhpmcounterK 0xB00+K/0xB80+K; user read-only aliases 0xC00/0xC80, 0xC02/0xC82, 0xC00+K/0xC80+K; mhpmeventK 0x320+K; mcountinhibit 0x320. K in 3..3+NUM_HPM-1.
- Increment per cycle, unless inhibited: mcycle +1 (inhibit bit 0); minstret +retire (bit 2); counter K +1 when mhpmeventK in 1..NUM_EVENTS and event_in[mhpmeventK-1]=1 (bit K). Selector 0 or >NUM_EVENTS: never counts.
- Arithmetic: modulo 2^CNT_WIDTH, wraps silently to 0; no sticky flag.
- mhpmevent stores 8 bits, reads zero-extended. mcountinhibit implements bits 0, 2, 3..3+NUM_HPM-1; other bits read 0. Bit 1 is always 0.
- Request handling: csr_req sampled at edge N. csr_ack=1, csr_rdata, csr_illegal are registered outputs valid during cycle N+1. csr_rdata is the value before edge N. New value = wdata (write), old|wdata (set), old&~wdata (clear), effective at edge N. Back-to-back requests are allowed; the second observes the first's write.
- Write vs increment at the same edge: the targeted counter takes the written half and skips its increment that cycle; the other half is held. Other counters increment normally. A write to mcountinhibit takes effect for increments from the next edge.
- Hi half read when CNT_WIDTH<64 returns counter[CNT_WIDTH-1:32] zero-extended.
- Illegal (csr_illegal=1, csr_rdata=0, no state change): unmapped address, K outside the implemented range, or op≠00 to a 0xCxx alias. Read-only op (00) to any mapped address is legal.
- Between requests csr_ack=0; csr_rdata/csr_illegal hold their last values.
- 0x320 (mcountinhibit) takes precedence over mhpmevent decode, since 0x320+K requires K≥3.

Test Plan:
- Release reset, idle 10 cycles, then read 0xC00 -> ack next cycle, rdata=10±1 per the documented edge count (exactly 10 counting from first non-reset edge); 0xC80 -> 0.
- Pulse retire 5 times, read 0xB02 -> 5; set mcountinhibit bit 2 (op 10, wdata 4), pulse retire 3 times -> minstret still 5.
- CNT_WIDTH=40: write 0xB80=0xFF, 0xB00=0xFFFFFFFE, wait 3 cycles -> mcycle wrapped, lo=1, hi=0.
- mhpmevent3=2 (0x323), event_in[1] high for 7 cycles, event_in[0] toggling -> read 0xB03 = 7; mhpmevent3=9 with NUM_EVENTS=8 -> no counting.
- Write 0xC00, read 0x7FF, access 0xB07 with NUM_HPM=4 -> csr_illegal=1, rdata=0, no counter changes.
- Back-to-back: clear 0xB00 with 0xFFFFFFFF then read 0xB00 next cycle -> first rdata = old value, second rdata = 0 (write edge skipped increment; one idle edge may have added 1 → expect exactly 1 if one edge passed between write and read sample).
